// File: rtl/multiplier_datapath_taint_track_pkg.sv
// Shared definitions for the taint-tracking multiplier datapath.
// Holds the running-sum operation encoding and the per-bit taint merge.
package multiplier_datapath_taint_track_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    RS_HOLD  = 2'd0,
    RS_SHR   = 2'd1,
    RS_LOAD  = 2'd2,
    RS_CLEAR = 2'd3
  } rs_op_e;

  // A tainted enable could have picked either the old or the new value,
  // so any bit where the two differ becomes tainted as well.
  function automatic logic taint_mux(input logic chosen, input logic chosen_t,
                                     input logic old, input logic old_t,
                                     input logic en_t);
    return chosen_t | (en_t & (old_t | (chosen ^ old)));
  endfunction

endpackage

// File: rtl/taint_adder.sv
// N-bit wrapping adder with carry-fill taint.
// A tainted operand bit can disturb every sum bit at or above it through the carry chain.
module taint_adder
  import multiplier_datapath_taint_track_pkg::*;
#(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] a_t,
  input  logic [N-1:0] b,
  input  logic [N-1:0] b_t,
  output logic [N-1:0] sum,
  output logic [N-1:0] sum_t
);

  logic [N-1:0] t;

  always_comb begin
    sum      = a + b;
    t        = a_t | b_t;
    sum_t    = '0;
    sum_t[0] = t[0];
    for (int k = 1; k < N; k++) begin
      sum_t[k] = sum_t[k-1] | t[k];
    end
  end

endmodule

// File: rtl/multiplier_datapath_taint_track.sv
// Shift-add datapath of the sequential multiplier with a bitwise taint shadow
// for the multiplicand, multiplier and running-sum registers.
module multiplier_datapath_taint_track
  import multiplier_datapath_taint_track_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplicand_t,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   multiplier_t,
  input  logic               rsload,
  input  logic               rsload_t,
  input  logic               rsclear,
  input  logic               rsclear_t,
  input  logic               rsshr,
  input  logic               rsshr_t,
  input  logic               mrld,
  input  logic               mrld_t,
  input  logic               mdld,
  input  logic               mdld_t,
  output logic [WIDTH-1:0]   multiplierReg,
  output logic [WIDTH-1:0]   multiplierReg_t,
  output logic [2*WIDTH-1:0] product,
  output logic [2*WIDTH-1:0] product_t
);

  localparam int RS_W = 2*WIDTH + 1;

  logic [WIDTH-1:0] md, md_t, mr, mr_t;
  logic [RS_W-1:0]  rs, rs_t;

  logic [WIDTH-1:0] md_nxt, md_nxt_t, mr_nxt, mr_nxt_t;
  logic [RS_W-1:0]  rs_chosen, rs_chosen_t, rs_nxt_t;
  logic [WIDTH:0]   add_sum, add_sum_t;
  logic             rs_en_t;
  rs_op_e           rs_op;

  // The carry bit rs[2W] joins the upper half so intermediate sums never lose their MSB.
  taint_adder #(.N(WIDTH + 1)) u_adder (
    .a     (rs[RS_W-1:WIDTH]),
    .a_t   (rs_t[RS_W-1:WIDTH]),
    .b     ({1'b0, md}),
    .b_t   ({1'b0, md_t}),
    .sum   (add_sum),
    .sum_t (add_sum_t)
  );

  always_comb begin
    md_nxt   = mdld ? multiplicand : md;
    mr_nxt   = mrld ? multiplier : mr;
    md_nxt_t = '0;
    mr_nxt_t = '0;
    for (int k = 0; k < WIDTH; k++) begin
      md_nxt_t[k] = taint_mux(md_nxt[k], mdld ? multiplicand_t[k] : md_t[k],
                              md[k], md_t[k], mdld_t);
      mr_nxt_t[k] = taint_mux(mr_nxt[k], mrld ? multiplier_t[k] : mr_t[k],
                              mr[k], mr_t[k], mrld_t);
    end
  end

  // Clear wins over load, load over shift; the control FSM never overlaps them anyway.
  always_comb begin
    if (rsclear)     rs_op = RS_CLEAR;
    else if (rsload) rs_op = RS_LOAD;
    else if (rsshr)  rs_op = RS_SHR;
    else             rs_op = RS_HOLD;

    rs_chosen   = rs;
    rs_chosen_t = rs_t;
    case (rs_op)
      RS_CLEAR: begin
        rs_chosen   = '0;
        rs_chosen_t = '0;
      end
      RS_LOAD: begin
        rs_chosen   = {add_sum, rs[WIDTH-1:0]};
        rs_chosen_t = {add_sum_t, rs_t[WIDTH-1:0]};
      end
      RS_SHR: begin
        rs_chosen   = {1'b0, rs[RS_W-1:1]};
        rs_chosen_t = {1'b0, rs_t[RS_W-1:1]};
      end
      default: ;
    endcase

    rs_en_t  = rsclear_t | rsload_t | rsshr_t;
    rs_nxt_t = '0;
    for (int k = 0; k < RS_W; k++) begin
      rs_nxt_t[k] = taint_mux(rs_chosen[k], rs_chosen_t[k], rs[k], rs_t[k], rs_en_t);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      md   <= '0;
      md_t <= '0;
      mr   <= '0;
      mr_t <= '0;
      rs   <= '0;
      rs_t <= '0;
    end else begin
      md   <= md_nxt;
      md_t <= md_nxt_t;
      mr   <= mr_nxt;
      mr_t <= mr_nxt_t;
      rs   <= rs_chosen;
      rs_t <= rs_nxt_t;
    end
  end

  assign multiplierReg   = mr;
  assign multiplierReg_t = mr_t;
  assign product         = rs[2*WIDTH-1:0];
  assign product_t       = rs_t[2*WIDTH-1:0];

endmodule

// File: tb/tb_multiplier_datapath_taint_track.sv
// Directed bench for the taint-tracking multiplier datapath.
// Plays the control FSM's strobe sequence and checks product and taint against hand-computed values.
module tb_multiplier_datapath_taint_track;

  localparam logic [4:0] S_SHR  = 5'b00001;
  localparam logic [4:0] S_LOAD = 5'b00010;
  localparam logic [4:0] S_CLR  = 5'b00100;
  localparam logic [4:0] S_MRLD = 5'b01000;
  localparam logic [4:0] S_MDLD = 5'b10000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] multiplicand = '0, multiplicand_t = '0;
  logic [3:0] multiplier = '0, multiplier_t = '0;
  logic       rsload = 1'b0, rsload_t = 1'b0;
  logic       rsclear = 1'b0, rsclear_t = 1'b0;
  logic       rsshr = 1'b0, rsshr_t = 1'b0;
  logic       mrld = 1'b0, mrld_t = 1'b0;
  logic       mdld = 1'b0, mdld_t = 1'b0;
  logic [3:0] multiplierReg, multiplierReg_t;
  logic [7:0] product, product_t;

  int checkCount = 0;
  int failCount  = 0;

  multiplier_datapath_taint_track #(.WIDTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .multiplicand    (multiplicand),
    .multiplicand_t  (multiplicand_t),
    .multiplier      (multiplier),
    .multiplier_t    (multiplier_t),
    .rsload          (rsload),
    .rsload_t        (rsload_t),
    .rsclear         (rsclear),
    .rsclear_t       (rsclear_t),
    .rsshr           (rsshr),
    .rsshr_t         (rsshr_t),
    .mrld            (mrld),
    .mrld_t          (mrld_t),
    .mdld            (mdld),
    .mdld_t          (mdld_t),
    .multiplierReg   (multiplierReg),
    .multiplierReg_t (multiplierReg_t),
    .product         (product),
    .product_t       (product_t)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Strobe bit order: {mdld, mrld, rsclear, rsload, rsshr}; held for exactly one clock.
  task automatic applyStimulus(input logic [4:0] strb, input logic [4:0] strb_t);
    {mdld, mrld, rsclear, rsload, rsshr}           = strb;
    {mdld_t, mrld_t, rsclear_t, rsload_t, rsshr_t} = strb_t;
    @(posedge clk);
    #1;
    {mdld, mrld, rsclear, rsload, rsshr}           = '0;
    {mdld_t, mrld_t, rsclear_t, rsload_t, rsshr_t} = '0;
  endtask

  // Mimics the control FSM; maxAdds > 0 stops right after that many loads.
  task automatic runMultiply(input logic [3:0] a, input logic [3:0] a_t,
                             input logic [3:0] b, input logic [3:0] b_t, input int maxAdds);
    int adds;
    adds           = 0;
    multiplicand   = a;
    multiplicand_t = a_t;
    multiplier     = b;
    multiplier_t   = b_t;
    applyStimulus(S_MDLD | S_MRLD | S_CLR, 5'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(S_SHR, 5'b0);
      if (b[i]) begin
        applyStimulus(S_LOAD, 5'b0);
        adds++;
        if (maxAdds != 0 && adds == maxAdds) return;
      end
    end
    applyStimulus(S_SHR, 5'b0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " mr"},    16'(multiplierReg),   16'h0);
    checkOutput({tag, " mr_t"},  16'(multiplierReg_t), 16'h0);
    checkOutput({tag, " prod"},  16'(product),         16'h0);
    checkOutput({tag, " prod_t"},16'(product_t),       16'h0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    rst = 1'b0;

    runMultiply(4'd3, 4'h0, 4'd5, 4'h0, 0);
    checkOutput("3x5 prod",   16'(product),         16'h000F);
    checkOutput("3x5 prod_t", 16'(product_t),       16'h0000);
    checkOutput("3x5 mr",     16'(multiplierReg),   16'h0005);
    checkOutput("3x5 mr_t",   16'(multiplierReg_t), 16'h0000);

    // Tainted shift of 0x0F: result 0x07, the bit that changed becomes tainted.
    applyStimulus(S_SHR, S_SHR);
    checkOutput("tshr prod",   16'(product),   16'h0007);
    checkOutput("tshr prod_t", 16'(product_t), 16'h0008);

    runMultiply(4'd15, 4'h0, 4'd15, 4'h0, 0);
    checkOutput("15x15 prod",   16'(product),   16'h00E1);
    checkOutput("15x15 prod_t", 16'(product_t), 16'h0000);

    runMultiply(4'd0, 4'h0, 4'd9, 4'h0, 0);
    checkOutput("0x9 prod", 16'(product), 16'h0000);
    runMultiply(4'd7, 4'h0, 4'd0, 4'h0, 0);
    checkOutput("7x0 prod", 16'(product),       16'h0000);
    checkOutput("7x0 mr",   16'(multiplierReg), 16'h0000);

    runMultiply(4'd1, 4'b0001, 4'd3, 4'h0, 0);
    checkOutput("taint prod",   16'(product),         16'h0003);
    checkOutput("taint prod_t", 16'(product_t),       16'h003F);
    checkOutput("taint mr_t",   16'(multiplierReg_t), 16'h0000);

    rst = 1'b1;
    #1;
    @(negedge clk);
    rst = 1'b0;
    multiplier   = 4'h6;
    multiplier_t = 4'b0100;
    applyStimulus(S_MRLD, 5'b0);
    checkOutput("mrld mr",   16'(multiplierReg),   16'h0006);
    checkOutput("mrld mr_t", 16'(multiplierReg_t), 16'h0004);
    multiplicand   = 4'h5;
    multiplicand_t = 4'h0;
    applyStimulus(S_MDLD, S_MDLD);
    checkOutput("tmdld md_t", 16'(dut.md_t), 16'h0005);

    // After two adds of 15x15 the partial sum reads 0x68 in the low byte.
    runMultiply(4'd15, 4'h0, 4'd15, 4'h0, 2);
    checkOutput("mid prod", 16'(product), 16'h0068);
    rst = 1'b1;
    #1;
    checkAllZero("midrst");
    @(negedge clk);
    rst = 1'b0;
    runMultiply(4'd6, 4'h0, 4'd7, 4'h0, 0);
    checkOutput("6x7 prod",   16'(product),   16'h002A);
    checkOutput("6x7 prod_t", 16'(product_t), 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
